// File: rtl/tta_icache.sv
// 2-way set-associative read-only instruction cache with 16-word line refill and line invalidation.
// Optional feature macro: ICACHE_PREFETCH_EN (refill on every IDLE miss, not just when get_i is high).
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_INIT | clearing valid/LRU one set per cycle after reset
// ST_IDLE | looking up pc_i every cycle
// ST_REQ  | line address latched, waiting for the memory queue to accept
// ST_FILL | collecting 16 beats into the victim way
module tta_icache #(
  parameter int WAYS      = 2,
  parameter int SETS_LOG2 = 6,
  parameter int LINE_LOG2 = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic        init_no,
  input  logic [15:0] pc_i,
  input  logic        get_i,
  output logic        hit_o,
  output logic [31:0] data_o,
  input  logic        invld_i,
  input  logic [15:0] iaddr_i,
  output logic        read_o,
  input  logic        full_i,
  input  logic        ready_i,
  output logic [15:0] addr_o,
  input  logic [31:0] data_i
);

  localparam int SETS      = 1 << SETS_LOG2;
  localparam int TAG_W     = 16 - SETS_LOG2 - LINE_LOG2;
  localparam int RAM_AW    = SETS_LOG2 + LINE_LOG2;
  localparam int RAM_WORDS = 1 << RAM_AW;
  localparam int LINE_W    = 16 - LINE_LOG2;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_REQ, ST_FILL} state_t;

  state_t state;

  logic [TAG_W-1:0] tag_q   [WAYS][SETS];
  logic             valid_q [WAYS][SETS];
  logic             lru_q   [SETS];
  logic [31:0]      ram_q   [WAYS][RAM_WORDS];

  logic [SETS_LOG2-1:0] init_cnt;
  logic [LINE_W-1:0]    fill_line;
  logic                 fill_way;
  logic                 fill_kill;
  logic [LINE_LOG2-1:0] beat_idx;

  logic [TAG_W-1:0]     pc_tag;
  logic [SETS_LOG2-1:0] pc_idx;
  logic [TAG_W-1:0]     i_tag;
  logic [SETS_LOG2-1:0] i_idx;
  logic [TAG_W-1:0]     fill_tag;
  logic [SETS_LOG2-1:0] fill_idx;
  logic [RAM_AW-1:0]    raddr;
  logic [RAM_AW-1:0]    waddr;

  logic [WAYS-1:0] way_hit;
  logic [WAYS-1:0] inv_match;
  logic            lookup_hit;
  logic            hit_way;
  logic            victim_sel;
  logic            refill_en;
  logic            kill_now;
  logic            ram_wr;

  assign pc_tag   = pc_i[15 -: TAG_W];
  assign pc_idx   = pc_i[LINE_LOG2 +: SETS_LOG2];
  assign i_tag    = iaddr_i[15 -: TAG_W];
  assign i_idx    = iaddr_i[LINE_LOG2 +: SETS_LOG2];
  assign fill_tag = fill_line[LINE_W-1 -: TAG_W];
  assign fill_idx = fill_line[SETS_LOG2-1:0];
  assign raddr    = pc_i[RAM_AW-1:0];
  assign waddr    = {fill_idx, beat_idx};

  always_comb begin
    way_hit   = '0;
    inv_match = '0;
    for (int w = 0; w < WAYS; w++) begin
      way_hit[w]   = valid_q[w][pc_idx] && (tag_q[w][pc_idx] == pc_tag);
      inv_match[w] = tag_q[w][i_idx] == i_tag;
    end
  end

  assign lookup_hit = |way_hit;
  assign hit_way    = way_hit[1];

  // Prefer an empty way; only fall back to LRU when the set is full.
  always_comb begin
    victim_sel = lru_q[pc_idx];
    if (!valid_q[0][pc_idx])
      victim_sel = 1'b0;
    else if (!valid_q[1][pc_idx])
      victim_sel = 1'b1;
  end

`ifdef ICACHE_PREFETCH_EN
  assign refill_en = 1'b1;
`else
  assign refill_en = get_i;
`endif

  assign kill_now = invld_i && (iaddr_i[15:LINE_LOG2] == fill_line);
  assign ram_wr   = (state == ST_FILL) && ready_i && !reset;

  always_ff @(posedge clock) begin
    if (ram_wr)
      ram_q[fill_way][waddr] <= data_i;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_INIT;
      init_cnt  <= '1;
      init_no   <= 1'b1;
      hit_o     <= 1'b0;
      data_o    <= '0;
      read_o    <= 1'b0;
      addr_o    <= '0;
      fill_line <= '0;
      fill_way  <= 1'b0;
      fill_kill <= 1'b0;
      beat_idx  <= '0;
    end else begin
      hit_o  <= 1'b0;
      read_o <= 1'b0;

      if (state != ST_INIT && invld_i) begin
        for (int w = 0; w < WAYS; w++)
          if (inv_match[w])
            valid_q[w][i_idx] <= 1'b0;
      end

      case (state)
        ST_INIT: begin
          for (int w = 0; w < WAYS; w++)
            valid_q[w][init_cnt] <= 1'b0;
          lru_q[init_cnt] <= 1'b0;
          if (init_cnt == '0) begin
            state   <= ST_IDLE;
            init_no <= 1'b0;
          end else begin
            init_cnt <= init_cnt - 1'b1;
          end
        end

        ST_IDLE: begin
          if (lookup_hit) begin
            hit_o  <= 1'b1;
            data_o <= ram_q[hit_way][raddr];
            // A same-cycle invalidation of this set wins over the LRU touch.
            if (!(invld_i && i_idx == pc_idx))
              lru_q[pc_idx] <= ~hit_way;
          end else if (refill_en) begin
            fill_line <= pc_i[15:LINE_LOG2];
            addr_o    <= {pc_i[15:LINE_LOG2], {LINE_LOG2{1'b0}}};
            fill_way  <= victim_sel;
            fill_kill <= 1'b0;
            beat_idx  <= '0;
            state     <= ST_REQ;
          end
        end

        ST_REQ: begin
          if (kill_now)
            fill_kill <= 1'b1;
          if (!full_i) begin
            read_o <= 1'b1;
            state  <= ST_FILL;
          end
        end

        ST_FILL: begin
          if (kill_now)
            fill_kill <= 1'b1;
          if (ready_i) begin
            beat_idx <= beat_idx + 1'b1;
            if (beat_idx == '1) begin
              tag_q[fill_way][fill_idx]   <= fill_tag;
              valid_q[fill_way][fill_idx] <= !(fill_kill || kill_now);
              lru_q[fill_idx]             <= ~fill_way;
              state                       <= ST_IDLE;
            end
          end
        end

        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_tta_icache.sv
// Self-checking bench for tta_icache: vector table for single-cycle lookups plus
// directed sequences for fills, eviction, back-pressure, invalidation and reset.
module tb_tta_icache;

  logic        clock;
  logic        reset;
  logic        init_no;
  logic [15:0] pc_i;
  logic        get_i;
  logic        hit_o;
  logic [31:0] data_o;
  logic        invld_i;
  logic [15:0] iaddr_i;
  logic        read_o;
  logic        full_i;
  logic        ready_i;
  logic [15:0] addr_o;
  logic [31:0] data_i;

  int errors = 0;
  int checks = 0;
  int read_cycles = 0;
  int hit_in_init = 0;
  logic [15:0] last_addr = 16'hFFFF;
  logic resp_busy = 1'b0;
  logic gap_en = 1'b0;

  tta_icache dut (
    .clock(clock), .reset(reset), .init_no(init_no),
    .pc_i(pc_i), .get_i(get_i), .hit_o(hit_o), .data_o(data_o),
    .invld_i(invld_i), .iaddr_i(iaddr_i),
    .read_o(read_o), .full_i(full_i), .ready_i(ready_i),
    .addr_o(addr_o), .data_i(data_i)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Memory contents: odd multiplier keeps each word distinct within the 64K space.
  function automatic logic [31:0] memf(input logic [15:0] a);
    logic [15:0] lo;
    lo = a * 16'h2F1B;
    return {a ^ 16'hC35A, lo};
  endfunction

  always @(negedge clock) begin
    if (read_o) read_cycles++;
    if (hit_o && init_no) hit_in_init++;
  end

  // Memory responder: 16 beats per read_o pulse, optionally with one idle cycle between beats.
  initial begin
    logic [15:0] base;
    ready_i = 1'b0;
    data_i  = '0;
    forever begin
      @(negedge clock);
      if (read_o) begin
        resp_busy = 1'b1;
        base      = addr_o;
        last_addr = addr_o;
        for (int k = 0; k < 16; k++) begin
          if (gap_en && k != 0) begin
            ready_i = 1'b0;
            @(negedge clock);
          end
          ready_i = 1'b1;
          data_i  = memf(base + 16'(k));
          @(negedge clock);
        end
        ready_i   = 1'b0;
        resp_busy = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_init(input string name);
    int n;
    int bad;
    n = 0;
    bad = 0;
    while (n < 300) begin
      @(negedge clock);
      n++;
      if (hit_o || read_o) bad++;
      if (!init_no) break;
    end
    chk({name, "_init_cycles"}, n, 64);
    chk({name, "_quiet_during_init"}, bad, 0);
  endtask

  // Hold pc with get_i high until hit_o, then check the delivered word.
  task automatic wait_hit(input logic [15:0] pc, input string name);
    int n;
    pc_i  = pc;
    get_i = 1'b1;
    n = 0;
    while (n < 300) begin
      @(negedge clock);
      n++;
      if (hit_o) break;
    end
    chk({name, "_hit"}, hit_o, 1'b1);
    chk({name, "_data"}, data_o, memf(pc));
    get_i = 1'b0;
  endtask

  task automatic look(input logic [15:0] pc, input logic get, input logic exp_hit, input string name);
    pc_i  = pc;
    get_i = get;
    @(negedge clock);
    chk({name, "_hit"}, hit_o, exp_hit);
    if (exp_hit) chk({name, "_data"}, data_o, memf(pc));
  endtask

  typedef struct {
    logic [15:0] pc;
    logic        get;
    logic        exp_hit;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int r0;
    int bad;
    int n;

    vecs[0] = '{16'h0002, 1'b1, 1'b1};
    vecs[1] = '{16'h0003, 1'b1, 1'b1};
    vecs[2] = '{16'h0004, 1'b1, 1'b1};
    vecs[3] = '{16'h0005, 1'b1, 1'b1};
    vecs[4] = '{16'h000F, 1'b1, 1'b1};
    vecs[5] = '{16'h0400, 1'b1, 1'b1};
    vecs[6] = '{16'h040F, 1'b1, 1'b1};
    vecs[7] = '{16'h0801, 1'b0, 1'b0};
    vecs[8] = '{16'h0011, 1'b0, 1'b0};
    vecs[9] = '{16'h0000, 1'b1, 1'b1};

    reset   = 1'b1;
    pc_i    = '0;
    get_i   = 1'b0;
    invld_i = 1'b0;
    iaddr_i = '0;
    full_i  = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_init_no", init_no, 1'b1);
    chk("rst_hit", hit_o, 1'b0);
    chk("rst_read", read_o, 1'b0);
    chk("rst_data", data_o, 32'h0);
    chk("rst_addr", addr_o, 16'h0);
    reset = 1'b0;
    wait_init("boot");

    // First fill: pc 0x0001.
    r0 = read_cycles;
    wait_hit(16'h0001, "fill1");
    chk("fill1_reads", read_cycles - r0, 1);
    chk("fill1_addr", last_addr, 16'h0000);

    // Same index, three different tags: third fill evicts the LRU line 0x000.
    wait_hit(16'h0401, "fill2");
    chk("fill2_addr", last_addr, 16'h0400);
    wait_hit(16'h0801, "fill3");
    chk("fill3_addr", last_addr, 16'h0800);
    look(16'h0401, 1'b1, 1'b1, "reuse_0401");
    r0 = read_cycles;
    look(16'h0001, 1'b1, 1'b0, "evicted_0001");
    wait_hit(16'h0001, "refill_0001");
    chk("refill_0001_reads", read_cycles - r0, 1);
    chk("refill_0001_addr", last_addr, 16'h0000);

    // Table: way0 holds line 0x000, way1 holds line 0x040.
    r0 = read_cycles;
    foreach (vecs[i]) begin
      pc_i  = vecs[i].pc;
      get_i = vecs[i].get;
      @(negedge clock);
      chk($sformatf("vec%0d_hit", i), hit_o, vecs[i].exp_hit);
      if (vecs[i].exp_hit)
        chk($sformatf("vec%0d_data", i), data_o, memf(vecs[i].pc));
    end
    get_i = 1'b0;
    chk("miss_get0_no_read", read_cycles - r0, 0);

    // Back-pressure: full_i high for 10 cycles, then a gapped fill.
    r0 = read_cycles;
    gap_en = 1'b1;
    full_i = 1'b1;
    pc_i   = 16'h0021;
    get_i  = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clock);
      if (read_o) bad++;
    end
    chk("full_no_read", bad, 0);
    full_i = 1'b0;
    wait_hit(16'h0021, "full_fill");
    chk("full_reads", read_cycles - r0, 1);
    chk("full_addr", last_addr, 16'h0020);
    gap_en = 1'b0;

    // Invalidate line 0x000 through a different word of the same line.
    pc_i    = 16'h0021;
    invld_i = 1'b1;
    iaddr_i = 16'h0007;
    @(negedge clock);
    invld_i = 1'b0;
    look(16'h0003, 1'b0, 1'b0, "inv_miss");
    look(16'h0401, 1'b0, 1'b1, "inv_other_way");
    r0 = read_cycles;
    wait_hit(16'h0003, "inv_refill");
    chk("inv_refill_reads", read_cycles - r0, 1);

    // Invalidate the line currently being filled: fill finishes but stays invalid.
    pc_i  = 16'h0041;
    get_i = 1'b1;
    n = 0;
    while (n < 50 && !read_o) begin
      @(negedge clock);
      n++;
    end
    chk("kill_read_seen", read_o, 1'b1);
    get_i   = 1'b0;
    invld_i = 1'b1;
    iaddr_i = 16'h0045;
    @(negedge clock);
    invld_i = 1'b0;
    n = 0;
    while (n < 60 && resp_busy) begin
      @(negedge clock);
      n++;
    end
    repeat (2) @(negedge clock);
    chk("kill_no_hit", hit_o, 1'b0);
    r0 = read_cycles;
    wait_hit(16'h0041, "kill_refill");
    chk("kill_refill_reads", read_cycles - r0, 1);

    // Reset in the middle of a fill; stray beats land while the cache reinitialises.
    pc_i  = 16'h0031;
    get_i = 1'b1;
    n = 0;
    while (n < 50 && !read_o) begin
      @(negedge clock);
      n++;
    end
    chk("mid_read_seen", read_o, 1'b1);
    get_i = 1'b0;
    repeat (6) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("mid_rst_hit", hit_o, 1'b0);
    chk("mid_rst_init_no", init_no, 1'b1);
    reset = 1'b0;
    wait_init("mid");
    look(16'h0031, 1'b0, 1'b0, "mid_0031_cleared");
    look(16'h0401, 1'b0, 1'b0, "mid_0401_cleared");
    r0 = read_cycles;
    wait_hit(16'h0031, "mid_refill");
    chk("mid_refill_reads", read_cycles - r0, 1);
    chk("mid_refill_addr", last_addr, 16'h0030);

    chk("hit_while_init", hit_in_init, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
